// File: rtl/window_framer.sv
// Frames a signed sample stream into N-sample windows (hop N or N/2), applies a
// loadable per-position coefficient with round-half-up and saturation, and tags frame positions.
module window_framer #(
  parameter int DATA_W  = 18,
  parameter int COEF_W  = 18,
  parameter int LOGSIZE = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               overlap,
  input  logic               coef_we,
  input  logic [LOGSIZE-1:0] coef_addr,
  input  logic [COEF_W-1:0]  coef_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [LOGSIZE-1:0] out_index,
  output logic               out_first,
  output logic               out_last
);

  localparam int N      = 1 << LOGSIZE;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic [LOGSIZE:0]   FULL   = (LOGSIZE+1)'(N);
  localparam logic [LOGSIZE:0]   HALF   = (LOGSIZE+1)'(N / 2);
  localparam logic [LOGSIZE-1:0] LAST_K = '1;
  localparam logic signed [PROD_W:0] ROUND   = (PROD_W+1)'(64'sd1 <<< (COEF_W - 2));
  localparam logic signed [PROD_W:0] SAT_MAX = (PROD_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W:0] SAT_MIN = (PROD_W+1)'(-(64'sd1 <<< (DATA_W - 1)));

  typedef enum logic [1:0] {FILL, EMIT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [LOGSIZE:0]   count_q, count_d;
  logic [LOGSIZE-1:0] base_q, base_d;
  logic [LOGSIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOGSIZE-1:0] k_q, k_d;
  logic               hop_sel_q, hop_sel_d;

  logic [DATA_W-1:0] sample_mem [N];
  logic [COEF_W-1:0] coef_mem [N];

  logic                     s1_valid_q, s1_valid_d;
  logic [LOGSIZE-1:0]       s1_index_q, s1_index_d;
  logic signed [DATA_W-1:0] s1_sample_q;
  logic [COEF_W-1:0]        s1_coef_q;

  logic                     s2_valid_q, s2_valid_d;
  logic [LOGSIZE-1:0]       s2_index_q, s2_index_d;
  logic signed [PROD_W-1:0] s2_prod_q, s2_prod_d;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [LOGSIZE-1:0] out_index_q, out_index_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;

  logic advance, issue, accept;
  logic [LOGSIZE-1:0]       rd_addr;
  logic [LOGSIZE:0]         hop;
  logic signed [PROD_W-1:0] samp_ext, coef_ext, product;
  logic signed [PROD_W:0]   sum, shifted;

  assign in_ready = !reset && (state_q == FILL) && (count_q < FULL);
  assign accept   = in_valid && in_ready;
  // A held output freezes every stage, so nothing is lost or duplicated.
  assign advance  = !(out_valid_q && !out_ready);
  assign issue    = (state_q == EMIT) && advance;
  assign rd_addr  = base_q + k_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    base_d    = base_q;
    wr_ptr_d  = wr_ptr_q;
    k_d       = k_q;
    hop_sel_d = hop_sel_q;
    hop       = hop_sel_q ? HALF : FULL;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + LOGSIZE'(1);
      count_d  = count_q + (LOGSIZE+1)'(1);
    end
    case (state_q)
      FILL: begin
        if (count_q == FULL) begin
          state_d   = EMIT;
          hop_sel_d = overlap;
          k_d       = '0;
        end
      end
      EMIT: begin
        if (issue) begin
          k_d = k_q + LOGSIZE'(1);
          if (k_q == LAST_K) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // With hop N/2 the newer half stays buffered as the next frame's first half.
        if (!s1_valid_q && !s2_valid_q && (!out_valid_q || out_ready)) begin
          state_d = FILL;
          base_d  = base_q + hop[LOGSIZE-1:0];
          count_d = count_q - hop;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_index_d  = s1_index_q;
    s2_valid_d  = s2_valid_q;
    s2_index_d  = s2_index_q;
    s2_prod_d   = s2_prod_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    samp_ext    = PROD_W'(s1_sample_q);
    coef_ext    = PROD_W'({1'b0, s1_coef_q});
    product     = samp_ext * coef_ext;
    sum         = (PROD_W+1)'(s2_prod_q) + ROUND;
    shifted     = sum >>> (COEF_W - 1);
    if (advance) begin
      s1_valid_d  = issue;
      if (issue) s1_index_d = k_q;
      s2_valid_d  = s1_valid_q;
      s2_index_d  = s1_index_q;
      s2_prod_d   = product;
      out_valid_d = s2_valid_q;
      out_index_d = s2_index_q;
      out_first_d = (s2_index_q == '0);
      out_last_d  = (s2_index_q == LAST_K);
      if (shifted > SAT_MAX)      out_data_d = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) out_data_d = SAT_MIN[DATA_W-1:0];
      else                        out_data_d = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      base_q      <= '0;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      hop_sel_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_index_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_index_q  <= '0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      base_q      <= base_d;
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      hop_sel_q   <= hop_sel_d;
      s1_valid_q  <= s1_valid_d;
      s1_index_q  <= s1_index_d;
      s2_valid_q  <= s2_valid_d;
      s2_index_q  <= s2_index_d;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  // RAMs and their read registers are deliberately unreset.
  always_ff @(posedge clk) begin
    if (coef_we) coef_mem[coef_addr] <= coef_wdata;
    if (accept)  sample_mem[wr_ptr_q] <= in_data;
    if (issue) begin
      s1_sample_q <= $signed(sample_mem[rd_addr]);
      s1_coef_q   <= coef_mem[k_q];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_window_framer.sv
// Directed, table-driven bench for window_framer with N=8: arithmetic vectors,
// overlap framing, backpressure hold and mid-frame reset.
module tb_window_framer;

  localparam int DATA_W  = 18;
  localparam int COEF_W  = 18;
  localparam int LOGSIZE = 3;
  localparam int N       = 8;
  localparam int ONE     = 131072;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, overlap, coef_we;
  logic out_valid, out_ready, out_first, out_last;
  logic [DATA_W-1:0]  in_data, out_data;
  logic [COEF_W-1:0]  coef_wdata;
  logic [LOGSIZE-1:0] coef_addr, out_index;

  typedef struct { int inSample; int coefVal; int expOut; } vec_t;
  typedef struct { int data; int index; int first; int last; int cyc; } obs_t;

  vec_t vecs [16];
  obs_t obsQ [$];
  obs_t obsItem;
  int cyc = 0;
  int passCount = 0;
  int checkCount = 0;
  int lastAcceptCyc = 0;
  int inReadyViolations = 0;

  window_framer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .LOGSIZE(LOGSIZE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .overlap(overlap), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake; input must never be accepted while a frame is out.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obsItem.data  = $signed(out_data);
      obsItem.index = int'(out_index);
      obsItem.first = int'(out_first);
      obsItem.last  = int'(out_last);
      obsItem.cyc   = cyc;
      obsQ.push_back(obsItem);
      if (in_ready) inReadyViolations++;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic loadCoef(input int addr, input int value);
    coef_we    = 1'b1;
    coef_addr  = LOGSIZE'(addr);
    coef_wdata = COEF_W'(value);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic applyStimulus(input int sample);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = DATA_W'(sample);
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("in_ready wait", 0, 1);
    tick();
    lastAcceptCyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic waitOutputs(input int n);
    int guard = 0;
    while (obsQ.size() < n && guard < 500) begin
      tick();
      guard++;
    end
    if (guard >= 500) checkOutput("output count wait", obsQ.size(), n);
  endtask

  task automatic waitIndex(input int k);
    int guard = 0;
    while (!(out_valid && int'(out_index) == k) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("wait for out_index", int'(out_index), k);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; overlap = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;

    // Frame A: unity window; frame B: rounding and saturation corners.
    for (int k = 0; k < N; k++) vecs[k] = '{k + 1, ONE, k + 1};
    vecs[8]  = '{3,       65536,  2};
    vecs[9]  = '{-3,      65536,  -1};
    vecs[10] = '{4,       65536,  2};
    vecs[11] = '{131071,  262143, 131071};
    vecs[12] = '{-131072, 262143, -131072};
    vecs[13] = '{1,       65536,  1};
    vecs[14] = '{-1,      65536,  0};
    vecs[15] = '{100,     0,      0};

    tick();
    tick();
    checkOutput("in_ready during reset", int'(in_ready), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset out_index", int'(out_index), 0);
    checkOutput("reset out_first", int'(out_first), 0);
    checkOutput("reset out_last", int'(out_last), 0);
    reset = 1'b0;
    tick();
    checkOutput("in_ready after reset", int'(in_ready), 1);

    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) loadCoef(k, vecs[f*N + k].coefVal);
      obsQ.delete();
      for (int k = 0; k < N; k++) applyStimulus(vecs[f*N + k].inSample);
      checkOutput($sformatf("f%0d in_ready low when full", f), int'(in_ready), 0);
      waitOutputs(N);
      if (obsQ.size() >= N) begin
        for (int k = 0; k < N; k++) begin
          checkOutput($sformatf("f%0d data k%0d", f, k), obsQ[k].data, vecs[f*N + k].expOut);
          checkOutput($sformatf("f%0d index k%0d", f, k), obsQ[k].index, k);
          checkOutput($sformatf("f%0d first k%0d", f, k), obsQ[k].first, int'(k == 0));
          checkOutput($sformatf("f%0d last k%0d", f, k), obsQ[k].last, int'(k == N - 1));
        end
        // One cycle to enter EMIT, then three pipeline stages.
        checkOutput($sformatf("f%0d latency", f), obsQ[0].cyc - lastAcceptCyc, 4);
        checkOutput($sformatf("f%0d throughput span", f), obsQ[N-1].cyc - obsQ[0].cyc, N - 1);
      end
      repeat (4) tick();
    end

    doReset();
    for (int k = 0; k < N; k++) loadCoef(k, ONE);
    overlap = 1'b1;
    obsQ.delete();
    inReadyViolations = 0;
    for (int s = 1; s <= 16; s++) applyStimulus(s);
    waitOutputs(3 * N);
    repeat (4) tick();
    checkOutput("overlap output count", obsQ.size(), 3 * N);
    if (obsQ.size() >= 3 * N) begin
      for (int i = 0; i < 3 * N; i++) begin
        checkOutput($sformatf("ovl data %0d", i), obsQ[i].data, 1 + 4 * (i / N) + (i % N));
        checkOutput($sformatf("ovl index %0d", i), obsQ[i].index, i % N);
      end
    end
    checkOutput("in_ready during emit", inReadyViolations, 0);
    overlap = 1'b0;

    doReset();
    obsQ.delete();
    for (int s = 1; s <= N; s++) applyStimulus(s);
    waitIndex(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall %0d out_valid", i), int'(out_valid), 1);
      checkOutput($sformatf("stall %0d out_data", i), $signed(out_data), 4);
      checkOutput($sformatf("stall %0d out_index", i), int'(out_index), 3);
      tick();
    end
    out_ready = 1'b1;
    waitOutputs(N);
    repeat (6) tick();
    checkOutput("stall output count", obsQ.size(), N);
    if (obsQ.size() >= N) begin
      for (int k = 0; k < N; k++) checkOutput($sformatf("stall seq %0d", k), obsQ[k].data, k + 1);
    end

    loadCoef(0, 0);
    for (int s = 21; s <= 28; s++) applyStimulus(s);
    waitIndex(5);
    reset = 1'b1;
    #1;
    checkOutput("in_ready while reset", int'(in_ready), 0);
    tick();
    checkOutput("out_valid after reset", int'(out_valid), 0);
    reset = 1'b0;
    #1;
    checkOutput("in_ready after release", int'(in_ready), 1);
    obsQ.delete();
    for (int s = 31; s <= 38; s++) applyStimulus(s);
    waitOutputs(N);
    repeat (6) tick();
    checkOutput("post-reset output count", obsQ.size(), N);
    if (obsQ.size() >= N) begin
      checkOutput("post-reset k0 zero coef", obsQ[0].data, 0);
      for (int k = 1; k < N; k++) checkOutput($sformatf("post-reset k%0d", k), obsQ[k].data, 31 + k);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
